// File: rtl/icache_dm_if.sv
// Fetch-side and system-bus signals of the direct-mapped instruction cache.
// The cache takes the slave view; the fetch stage and bus fabric take the master view.
interface icache_dm_if;
    logic [31:0] lookup_addr;
    logic        lookup_en;
    logic [31:0] hold_addr;
    logic        invalidate;
    logic        stall_req;
    logic [31:0] inst;
    logic        error;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport slave (
        input  lookup_addr, lookup_en, hold_addr, invalidate,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
        output stall_req, inst, error, bus_req, bus_addr
    );

    modport master (
        output lookup_addr, lookup_en, hold_addr, invalidate,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err,
        input  stall_req, inst, error, bus_req, bus_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: two-cycle lookup (array read, then compare)
// with a whole-line refill over single-word bus reads on a miss.
module icache_dm #(
    parameter int          LINES    = 64,
    parameter int          WORDS    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic        clk,
    input logic        rst_n,
    icache_dm_if.slave cif
);
    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - 2 - WB - IB;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

    state_t          state;
    logic [LINES-1:0] valid;
    logic [TW-1:0]   tag_mem  [LINES];
    logic [31:0]     data_mem [LINES*WORDS];
    logic [TW-1:0]   rd_tag;
    logic [31:0]     rd_line  [WORDS];
    logic [TW-1:0]   fill_tag;
    logic [IB-1:0]   fill_idx;
    logic [WB-1:0]   beat;
    logic            kill;

    logic [IB-1:0]   hold_idx;
    logic [TW-1:0]   hold_tag;
    logic [WB-1:0]   hold_word;
    logic [IB-1:0]   lookup_idx;
    logic [IB-1:0]   read_idx;
    logic            read_force;
    logic            read_en;
    logic            hit;
    logic            write_beat;
    logic            last_beat;
    logic            addr_unused;

    assign hold_idx    = cif.hold_addr[2+WB +: IB];
    assign hold_tag    = cif.hold_addr[31 -: TW];
    assign hold_word   = cif.hold_addr[2 +: WB];
    assign lookup_idx  = cif.lookup_addr[2+WB +: IB];
    assign addr_unused = ^{cif.lookup_addr[31 -: TW], cif.lookup_addr[2+WB-1:0], cif.hold_addr[1:0]};

    // After a refill or an error the read registers must reflect the held PC, not the next one.
    assign read_force = (state == DONE) || (state == ERR);
    assign read_en    = cif.lookup_en || read_force;
    assign read_idx   = read_force ? hold_idx : lookup_idx;

    assign hit        = valid[hold_idx] && (rd_tag == hold_tag);
    assign write_beat = (state == WAIT) && cif.bus_rvalid && !cif.bus_err;
    assign last_beat  = (beat == WB'(WORDS - 1));

    assign cif.stall_req = rst_n && ((state == IDLE) ? !hit : (state != ERR));
    assign cif.inst      = ((state == IDLE) && hit) ? rd_line[hold_word] : NOP_INST;
    assign cif.bus_addr  = {fill_tag, fill_idx, beat, 2'b00};

    always_ff @(posedge clk) begin
        if (write_beat) begin
            data_mem[{fill_idx, beat}] <= cif.bus_rdata;
            if (last_beat) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag <= '0;
            for (int w = 0; w < WORDS; w++) begin
                rd_line[w] <= '0;
            end
        end else if (read_en) begin
            rd_tag <= tag_mem[read_idx];
            for (int w = 0; w < WORDS; w++) begin
                rd_line[w] <= data_mem[{read_idx, WB'(w)}];
            end
        end
    end

    // An invalidate seen during a refill poisons that refill so its line is never validated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            fill_tag    <= '0;
            fill_idx    <= '0;
            kill        <= 1'b0;
            valid       <= '0;
            cif.bus_req <= 1'b0;
            cif.error   <= 1'b0;
        end else begin
            cif.error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!hit) begin
                        fill_tag    <= hold_tag;
                        fill_idx    <= hold_idx;
                        beat        <= '0;
                        kill        <= 1'b0;
                        cif.bus_req <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (cif.bus_gnt) begin
                        cif.bus_req <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cif.bus_rvalid) begin
                        if (cif.bus_err) begin
                            cif.error <= 1'b1;
                            state     <= ERR;
                        end else if (last_beat) begin
                            if (!kill) begin
                                valid[fill_idx] <= 1'b1;
                            end
                            state <= DONE;
                        end else begin
                            beat        <= beat + 1'b1;
                            cif.bus_req <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (cif.invalidate) begin
                valid <= '0;
                if ((state == REQ) || (state == WAIT)) begin
                    kill <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hits, eviction, bus error, invalidate and reset mid-refill.
module tb_icache_dm;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    icache_dm_if cif();

    icache_dm #(
        .LINES    (64),
        .WORDS    (4),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cif   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hA0 + {30'b0, a[3:2]} + ({20'b0, a[15:4]} << 8);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        cif.bus_rvalid = 1'b0;
        cif.bus_err    = 1'b0;
        cif.invalidate = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] hold, input logic [31:0] lookup, input logic en);
        cif.hold_addr   = hold;
        cif.lookup_addr = lookup;
        cif.lookup_en   = en;
        #1;
    endtask

    // Called in the miss cycle M; returns in cycle M+10 (or in the ERR cycle on a bus error).
    task automatic refill(input logic [31:0] base, input int err_beat, input int inv_beat);
        checkOutput("miss_stall", {31'b0, cif.stall_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            if (k == inv_beat) cif.invalidate = 1'b1;
            #1;
            checkOutput("req_valid", {31'b0, cif.bus_req}, 32'd1);
            checkOutput("req_addr", cif.bus_addr, base + 32'(4 * k));
            checkOutput("req_stall", {31'b0, cif.stall_req}, 32'd1);
            nextCycle();
            cif.bus_rvalid = 1'b1;
            cif.bus_rdata  = memWord(base + 32'(4 * k));
            cif.bus_err    = (k == err_beat);
            #1;
            checkOutput("wait_noreq", {31'b0, cif.bus_req}, 32'd0);
            checkOutput("wait_stall", {31'b0, cif.stall_req}, 32'd1);
            if (k == err_beat) begin
                nextCycle();
                #1;
                checkOutput("err_pulse", {31'b0, cif.error}, 32'd1);
                checkOutput("err_stall", {31'b0, cif.stall_req}, 32'd0);
                checkOutput("err_inst", cif.inst, 32'h0000_0013);
                return;
            end
        end
        nextCycle();
        #1;
        checkOutput("done_stall", {31'b0, cif.stall_req}, 32'd1);
        checkOutput("done_noreq", {31'b0, cif.bus_req}, 32'd0);
        nextCycle();
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        cif.invalidate = 1'b0;
        cif.bus_gnt    = 1'b1;
        cif.bus_rvalid = 1'b0;
        cif.bus_rdata  = '0;
        cif.bus_err    = 1'b0;
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("rst_req", {31'b0, cif.bus_req}, 32'd0);
        checkOutput("rst_error", {31'b0, cif.error}, 32'd0);
        checkOutput("rst_inst", cif.inst, 32'h0000_0013);

        // Cold miss
        rst_n = 1'b1;
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        refill(32'h8000_0000, -1, -1);
        checkOutput("cold_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("cold_inst", cif.inst, 32'h0000_00A0);

        // Same-line hits
        applyStimulus(32'h8000_0000, 32'h8000_0004, 1'b1);
        nextCycle();
        applyStimulus(32'h8000_0004, 32'h8000_0008, 1'b1);
        checkOutput("hit1_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("hit1_inst", cif.inst, 32'h0000_00A1);
        checkOutput("hit1_noreq", {31'b0, cif.bus_req}, 32'd0);
        nextCycle();
        applyStimulus(32'h8000_0008, 32'h8000_0400, 1'b1);
        checkOutput("hit2_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("hit2_inst", cif.inst, 32'h0000_00A2);
        checkOutput("hit2_noreq", {31'b0, cif.bus_req}, 32'd0);

        // Conflict eviction
        nextCycle();
        applyStimulus(32'h8000_0400, 32'h8000_0400, 1'b0);
        refill(32'h8000_0400, -1, -1);
        checkOutput("evict_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("evict_inst", cif.inst, 32'h0000_40A0);
        applyStimulus(32'h8000_0400, 32'h8000_0000, 1'b1);
        nextCycle();
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        refill(32'h8000_0000, -1, -1);
        checkOutput("back_inst", cif.inst, 32'h0000_00A0);

        // Bus error on beat 2
        applyStimulus(32'h8000_0000, 32'h8000_0010, 1'b1);
        nextCycle();
        applyStimulus(32'h8000_0010, 32'h8000_0010, 1'b0);
        refill(32'h8000_0010, 2, -1);
        nextCycle();
        #1;
        checkOutput("err_once", {31'b0, cif.error}, 32'd0);
        refill(32'h8000_0010, -1, -1);
        checkOutput("err_refill_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("err_refill_inst", cif.inst, 32'h0000_01A0);

        // Invalidate during beat 1
        applyStimulus(32'h8000_0010, 32'h8000_0020, 1'b1);
        nextCycle();
        applyStimulus(32'h8000_0020, 32'h8000_0020, 1'b0);
        refill(32'h8000_0020, -1, 1);
        refill(32'h8000_0020, -1, -1);
        checkOutput("inv_refill_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("inv_refill_inst", cif.inst, 32'h0000_02A0);
        applyStimulus(32'h8000_0020, 32'h8000_0000, 1'b1);
        nextCycle();
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("inv_old_miss", {31'b0, cif.stall_req}, 32'd1);

        // Reset in the middle of the refill
        nextCycle();
        #1;
        checkOutput("mid_req0", {31'b0, cif.bus_req}, 32'd1);
        nextCycle();
        cif.bus_rvalid = 1'b1;
        cif.bus_rdata  = memWord(32'h8000_0000);
        nextCycle();
        #1;
        checkOutput("mid_req1", {31'b0, cif.bus_req}, 32'd1);
        checkOutput("mid_addr1", cif.bus_addr, 32'h8000_0004);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_req", {31'b0, cif.bus_req}, 32'd0);
        checkOutput("rst_async_stall", {31'b0, cif.stall_req}, 32'd0);
        nextCycle();
        nextCycle();
        rst_n          = 1'b1;
        cif.bus_rvalid = 1'b1;
        cif.bus_rdata  = 32'hDEAD_BEEF;
        #1;
        refill(32'h8000_0000, -1, -1);
        checkOutput("post_rst_stall", {31'b0, cif.stall_req}, 32'd0);
        checkOutput("post_rst_inst", cif.inst, 32'h0000_00A0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage; it supplies the 32-bit instruction for the fetch PC.
- Lookup is split over two cycles:
  - Cycle N: fetch presents the next PC and the arrays are read.
  - Cycle N+1: fetch presents the registered PC, and the tag compare and data return happen.
- On a miss, the block raises a stall request and refills the whole line over the system bus with single-word reads.

Parameters:
- LINES, 64, number of lines; power of two, minimum 2.
- WORDS, 4, 32-bit words per line; power of two, minimum 2.
- NOP_INST, 32'h00000013, instruction returned alongside an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_addr  in  32  next fetch PC; indexes the arrays.
- lookup_en  in  1  array read enable; fetch drives 1 when not stalled.
- hold_addr  in  32  registered fetch PC; equals lookup_addr of the previous enabled cycle.
- invalidate  in  1  one-cycle pulse (fence.i): clear all valid bits.
- stall_req  out  1  inst is not yet valid for hold_addr; fetch must hold.
- inst  out  32  instruction for hold_addr; meaningful when stall_req=0.
- error  out  1  bus error on this fetch; one-cycle pulse.
- bus_req  out  1  read request.
- bus_addr  out  32  word-aligned read address.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.
- bus_err  in  1  error qualifier, sampled with bus_rvalid.

Behaviour:
- Address split: offset=[1:0] (ignored); word=[2+log2(WORDS)-1:2]; index=next log2(LINES) bits; tag=remaining upper bits.
- Storage:
  - Tag and data arrays use synchronous read, registered output.
  - Valid bits are flops, so they can be cleared in a single cycle.
- Reset (asynchronous, rst_n=0):
  - All valid bits cleared; FSM=IDLE; beat=0.
  - bus_req=0, error=0, stall_req=0, inst=NOP_INST.
  - Read output registers cleared.
  - Arrays are not cleared.
- Array read:
  - When lookup_en=1, the arrays read lookup_addr's index at the clock edge.
  - When lookup_en=0, the read registers hold their value.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - hit = valid[index(hold_addr)] && stored tag == tag(hold_addr).
  - Hit: stall_req=0, inst = read word selected by word(hold_addr).
  - Miss: stall_req=1 combinationally in the same cycle; latch the line base (hold_addr with word and offset bits zeroed); beat=0; go to REQ.
- REQ:
  - bus_req=1; bus_addr = line base + 4*beat; stall_req=1.
  - bus_gnt=1 -> WAIT. bus_req and bus_addr stay stable until bus_gnt.
- WAIT:
  - bus_req=0; stall_req=1; wait for bus_rvalid.
  - rvalid with err=0: write bus_rdata to data[index][beat].
    - Not the last beat: beat+1 -> REQ.
    - Last beat: write the tag, set valid -> DONE.
  - rvalid with err=1: the line stays invalid -> ERR.
- DONE:
  - stall_req=1; force an array read at index(hold_addr), regardless of lookup_en.
  - Go to IDLE; the compare in IDLE then hits.
- ERR:
  - One cycle: stall_req=0, error=1, inst=NOP_INST.
  - Force an array read at index(hold_addr), then go to IDLE.
- Miss latency, with immediate gnt and rvalid one cycle after gnt:
  - Miss detected in cycle M.
  - Beat k request in cycle M+1+2k; beat k data in cycle M+2+2k.
  - DONE in cycle M+2*WORDS+1.
  - Hit and stall_req=0 in cycle M+2*WORDS+2 (M+10 at WORDS=4).
- Wrap-around: beat counts 0..WORDS-1; the address never crosses the line base.
- invalidate:
  - Clears all valid bits in any state.
  - If asserted during REQ or WAIT, it also sets a kill flag. The refill completes, but the line is not validated, so the compare after DONE misses and the line is refilled again.
  - invalidate in the same cycle as the last-beat write: invalidate wins; the line stays invalid.
- bus_rvalid outside WAIT (for example, a stale response after reset) is ignored.
- Reset mid-refill: bus_req drops immediately (asynchronously). The partially written line stays invalid.

Test Plan:
- Cold miss:
  - Stimulus: reset; present lookup_addr=0x80000000, then hold_addr=0x80000000. Bus returns 0xA0,0xA1,0xA2,0xA3 with gnt immediate and rvalid one cycle after gnt.
  - Response: bus_addr sequence 0x80000000/04/08/0C; stall_req=1 for cycles M..M+9; inst=0xA0 with stall_req=0 at M+10.
- Same-line hits:
  - Stimulus: after the cold miss, sequential PCs 0x80000004, 0x80000008.
  - Response: stall_req=0; inst=0xA1 then 0xA2 on consecutive cycles; no bus_req.
- Conflict eviction:
  - Stimulus: fetch 0x80000400 (same index as 0x80000000, different tag, LINES=64), then 0x80000000 again.
  - Response: each fetch misses and refills.
- Bus error:
  - Stimulus: bus_err=1 on beat 2 of a refill.
  - Response: error=1 for exactly one cycle with inst=0x00000013 and stall_req=0; a refetch of the same PC misses again.
- invalidate during refill:
  - Stimulus: pulse invalidate during beat 1.
  - Response: the refill completes, then a second full refill of the same line; previously cached lines miss.
- Reset mid-refill:
  - Stimulus: drive rst_n low during WAIT.
  - Response: bus_req=0 immediately; a stale rvalid is ignored; the first fetch after reset misses.
